uart_tx_arbiter: RTL and testbench

- Shares one UART transmit path (TX FIFO write port: wr_uart / wr_data / tx_full) between NUM_REQ independent requesters.
- Uses round-robin arbitration with packet lock: once granted, a requester owns the TX FIFO until its last byte is written or a burst cap is reached.
- Sits between on-chip byte sources (console, debug dump, status reporter) and uart_wrapper.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit-side blocks.
package uart_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Wrapped increment of a round-robin pointer. The wrap is an explicit
    // compare so that non-power-of-2 requester counts work.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input int unsigned num_req);
        return (ptr == num_req - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping back to 0.
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_req
);

    int         idx;
    logic [PTR_W-1:0] sel;
    logic       found;

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        winner  = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port between several
// byte sources. A grant is locked until the owner's last byte is written or
// MAX_BURST bytes have gone through, so packets never interleave.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no owner; pick next requester from rr_ptr (no transfer)
// ARB_GRANT | grant_id owns the FIFO write port until last/burst cap
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          tx_full,
    output logic                          wr_uart,
    output logic [DATA_BITS-1:0]          wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          burst_cut
);

    import uart_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick_idx;
    logic             any_req;
    logic [BC_W-1:0]  burst_cnt;

    logic [DATA_BITS-1:0] data_arr [NUM_REQ];

    logic in_grant;
    logic owner_valid;
    logic owner_last;
    logic xfer;
    logic cap_hit;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*DATA_BITS +: DATA_BITS];
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .winner  (pick_idx),
        .any_req (any_req)
    );

    // Owner-side datapath: the FIFO write and ready are combinational on
    // tx_full so a byte moves in the same cycle the FIFO has room.
    always_comb begin
        in_grant    = (state == ARB_GRANT);
        owner_valid = req_valid[grant_id];
        owner_last  = req_last[grant_id];
        xfer        = in_grant & owner_valid & ~tx_full;
        cap_hit     = (burst_cnt == BC_W'(MAX_BURST - 1));
        wr_uart     = xfer;
        burst_cut   = xfer & ~owner_last & cap_hit;
        wr_data     = in_grant ? data_arr[grant_id] : '0;
        busy        = in_grant;
        req_ready   = '0;
        if (in_grant && !tx_full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Grant FSM: arbitrate in IDLE, count bytes and release in GRANT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant_id  <= pick_idx;
                        burst_cnt <= '0;
                        state     <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (xfer) begin
                        if (owner_last || cap_hit) begin
                            state  <= ARB_IDLE;
                            rr_ptr <= PTR_W'(rr_next(32'(grant_id), NUM_REQ));
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed vector table, packet-source
// scenarios and randomized traffic checked against a behavioural model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            tx_full = 1'b0;
    logic            wr_uart;
    logic [DB-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic            burst_cut;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (N),
        .DATA_BITS (DB),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_full   (tx_full),
        .wr_uart   (wr_uart),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .burst_cut (burst_cut)
    );

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: owner index (-1 = none), bytes in grant, rr pointer
    int         m_owner;
    int         m_cnt;
    int         m_ptr;
    logic       e_wr, e_busy, e_cut;
    logic [7:0] e_data;
    logic [3:0] e_ready;

    // packet sources
    int         src_cnt  [N];
    int         src_sent [N];
    logic [7:0] src_base [N];
    bit         src_pause[N];
    bit         use_src;
    int         log_own[$];
    logic [7:0] log_dat[$];
    int         dut_wr_seen;
    int         dut_cut_seen;
    bit         xfer_now;
    int         xfer_owner;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] base;
        logic       full;
        logic       exp_wr;
        logic [7:0] exp_data;
        logic [3:0] exp_ready;
        logic       exp_busy;
        logic [1:0] exp_gid;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [7:0] b, logic f,
                                logic ew, logic [7:0] ed, logic [3:0] er,
                                logic eb, logic [1:0] eg);
        vec_t r;
        r.valid = v; r.last = l; r.base = b; r.full = f;
        r.exp_wr = ew; r.exp_data = ed; r.exp_ready = er;
        r.exp_busy = eb; r.exp_gid = eg;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_eval();
        e_wr = 1'b0; e_busy = 1'b0; e_cut = 1'b0; e_data = '0; e_ready = '0;
        if (m_owner >= 0) begin
            e_busy  = 1'b1;
            e_ready = tx_full ? 4'b0000 : 4'(1 << m_owner);
            e_wr    = req_valid[m_owner] && !tx_full;
            e_data  = req_data[m_owner*DB +: DB];
            e_cut   = e_wr && !req_last[m_owner] && (m_cnt == MB - 1);
        end
    endtask

    task automatic model_advance();
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_owner < 0 && req_valid[i]) begin
                    m_owner = i;
                    m_cnt   = 0;
                end
            end
        end else if (e_wr) begin
            if (req_last[m_owner] || m_cnt == MB - 1) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_cnt[i] > 0) && !src_pause[i];
            req_last[i]  = (src_cnt[i] == 1);
            req_data[i*DB +: DB] = src_base[i] + 8'(src_sent[i]);
        end
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < N; i++) if (src_cnt[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0; src_sent[i] = 0; src_base[i] = '0; src_pause[i] = 1'b0;
        end
        log_own.delete();
        log_dat.delete();
        dut_wr_seen  = 0;
        dut_cut_seen = 0;
    endtask

    // called at posedge+1; samples at the following negedge
    task automatic sample_half(input bit chk);
        if (use_src) drive_src();
        @(negedge clk);
        model_eval();
        if (chk) begin
            cmp("wr_uart", wr_uart, e_wr);
            cmp("wr_data", wr_data, e_data);
            cmp("req_ready", req_ready, e_ready);
            cmp("busy", busy, e_busy);
            cmp("burst_cut", burst_cut, e_cut);
            if (e_busy) cmp("grant_id", grant_id, 32'(m_owner));
        end
        if (wr_uart === 1'b1)   dut_wr_seen++;
        if (burst_cut === 1'b1) dut_cut_seen++;
    endtask

    task automatic edge_half();
        @(posedge clk);
        xfer_now   = e_wr;
        xfer_owner = m_owner;
        if (xfer_now && use_src) begin
            log_own.push_back(xfer_owner);
            log_dat.push_back(src_base[xfer_owner] + 8'(src_sent[xfer_owner]));
            src_cnt[xfer_owner]--;
            src_sent[xfer_owner]++;
        end
        model_advance();
        #1;
    endtask

    task automatic step(input bit chk);
        sample_half(chk);
        edge_half();
    endtask

    task automatic run_until_idle(input int bound, input string name);
        int c = 0;
        while ((src_pending() || m_owner >= 0) && c < bound) begin
            step(1'b1);
            c++;
        end
        if (c >= bound) begin
            n_cmp++; n_err++;
            $display("FAIL %s: timeout after %0d cycles, required idle", name, c);
        end
    endtask

    task automatic wait_log(input int n, input int bound, input string name);
        int c = 0;
        while (log_own.size() < n && c < bound) begin
            step(1'b1);
            c++;
        end
        if (c >= bound) begin
            n_cmp++; n_err++;
            $display("FAIL %s: got %0d bytes, required %0d", name, log_own.size(), n);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        use_src   = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_full   = 1'b0;
        #1;
        cmp("rst_busy", busy, 0);
        cmp("rst_wr_uart", wr_uart, 0);
        cmp("rst_wr_data", wr_data, 0);
        cmp("rst_req_ready", req_ready, 0);
        cmp("rst_grant_id", grant_id, 0);
        cmp("rst_burst_cut", burst_cut, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        clear_src();
    endtask

    task automatic check_log(input string name, input int exp_own[$], input int exp_dat[$]);
        cmp({name, "_count"}, log_own.size(), exp_own.size());
        for (int k = 0; k < exp_own.size() && k < log_own.size(); k++) begin
            cmp($sformatf("%s_owner%0d", name, k), log_own[k], exp_own[k]);
            cmp($sformatf("%s_data%0d", name, k), log_dat[k], exp_dat[k]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int eo[$];
        int ed[$];
        int w0;

        model_reset();
        clear_src();
        use_src = 1'b0;
        do_reset();

        // directed table: valid, last, data base, full | wr, data, ready, busy, gid
        tbl[0]  = mk(4'b0001, 4'b0000, 8'h41, 0, 0, 8'h00, 4'b0000, 0, 0);
        tbl[1]  = mk(4'b0001, 4'b0000, 8'h41, 0, 1, 8'h41, 4'b0001, 1, 0);
        tbl[2]  = mk(4'b0001, 4'b0000, 8'h42, 0, 1, 8'h42, 4'b0001, 1, 0);
        tbl[3]  = mk(4'b0001, 4'b0001, 8'h43, 0, 1, 8'h43, 4'b0001, 1, 0);
        tbl[4]  = mk(4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 4'b0000, 0, 0);
        tbl[5]  = mk(4'b0011, 4'b0011, 8'h50, 0, 0, 8'h00, 4'b0000, 0, 0);
        tbl[6]  = mk(4'b0011, 4'b0011, 8'h50, 0, 1, 8'h51, 4'b0010, 1, 1);
        tbl[7]  = mk(4'b0011, 4'b0011, 8'h60, 0, 0, 8'h00, 4'b0000, 0, 0);
        tbl[8]  = mk(4'b0011, 4'b0001, 8'h70, 0, 1, 8'h70, 4'b0001, 1, 0);
        tbl[9]  = mk(4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 4'b0000, 0, 0);
        tbl[10] = mk(4'b0010, 4'b0000, 8'h00, 0, 0, 8'h00, 4'b0000, 0, 0);
        tbl[11] = mk(4'b0010, 4'b0000, 8'h90, 1, 0, 8'h91, 4'b0000, 1, 1);
        tbl[12] = mk(4'b0010, 4'b0010, 8'h80, 0, 1, 8'h81, 4'b0010, 1, 1);
        tbl[13] = mk(4'b0000, 4'b0000, 8'h00, 0, 0, 8'h00, 4'b0000, 0, 0);

        for (int t = 0; t < 14; t++) begin
            req_valid = tbl[t].valid;
            req_last  = tbl[t].last;
            tx_full   = tbl[t].full;
            for (int i = 0; i < N; i++) req_data[i*DB +: DB] = tbl[t].base + 8'(i);
            sample_half(1'b0);
            cmp($sformatf("tbl%0d_wr", t), wr_uart, tbl[t].exp_wr);
            cmp($sformatf("tbl%0d_data", t), wr_data, tbl[t].exp_data);
            cmp($sformatf("tbl%0d_ready", t), req_ready, tbl[t].exp_ready);
            cmp($sformatf("tbl%0d_busy", t), busy, tbl[t].exp_busy);
            cmp($sformatf("tbl%0d_cut", t), burst_cut, 0);
            if (tbl[t].exp_busy) cmp($sformatf("tbl%0d_gid", t), grant_id, tbl[t].exp_gid);
            edge_half();
        end

        // four requesters, 2-byte packets each: strict order 0,1,2,3
        do_reset();
        use_src = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 2; src_base[i] = 8'(16 * i);
        end
        run_until_idle(60, "rr4_done");
        eo.delete(); ed.delete();
        for (int k = 0; k < 8; k++) begin
            eo.push_back(k / 2); ed.push_back((k / 2) * 16 + (k % 2));
        end
        check_log("rr4", eo, ed);

        // burst cap: req2 20 bytes, req1 joins after req2 is granted
        do_reset();
        use_src = 1'b1;
        src_cnt[2] = 20; src_base[2] = 8'h20;
        step(1'b1);
        step(1'b1);
        src_cnt[1] = 2; src_base[1] = 8'h60;
        run_until_idle(100, "burst_done");
        eo.delete(); ed.delete();
        for (int k = 0; k < 16; k++) begin eo.push_back(2); ed.push_back(8'h20 + k); end
        for (int k = 0; k < 2; k++)  begin eo.push_back(1); ed.push_back(8'h60 + k); end
        for (int k = 0; k < 4; k++)  begin eo.push_back(2); ed.push_back(8'h30 + k); end
        check_log("burst", eo, ed);
        cmp("burst_cut_pulses", dut_cut_seen, 1);

        // tx_full held for 10 cycles in the middle of a req1 packet
        do_reset();
        use_src = 1'b1;
        src_cnt[1] = 4; src_base[1] = 8'h40;
        wait_log(2, 20, "full_pre");
        tx_full = 1'b1;
        w0 = dut_wr_seen;
        repeat (10) step(1'b1);
        cmp("full_no_write", dut_wr_seen - w0, 0);
        cmp("full_gid_held", grant_id, 1);
        tx_full = 1'b0;
        step(1'b1);
        cmp("full_resume", log_own.size(), 3);
        run_until_idle(40, "full_done");
        eo.delete(); ed.delete();
        for (int k = 0; k < 4; k++) begin eo.push_back(1); ed.push_back(8'h40 + k); end
        check_log("full", eo, ed);

        // asynchronous reset during the 2nd byte of a req3 packet
        do_reset();
        use_src = 1'b1;
        src_cnt[3] = 4; src_base[3] = 8'h70;
        wait_log(1, 20, "rst_mid_pre");
        drive_src();
        #2;
        cmp("rst_mid_before", wr_uart, 1);
        reset = 1'b0;
        #1;
        cmp("rst_mid_wr", wr_uart, 0);
        cmp("rst_mid_busy", busy, 0);
        cmp("rst_mid_ready", req_ready, 0);
        cmp("rst_mid_data", wr_data, 0);
        cmp("rst_mid_gid", grant_id, 0);
        cmp("rst_mid_cut", burst_cut, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        clear_src();
        use_src = 1'b1;
        src_cnt[0] = 1; src_base[0] = 8'h01;
        src_cnt[3] = 2; src_base[3] = 8'h05;
        run_until_idle(40, "rst_mid_done");
        eo = '{0, 3, 3};
        ed = '{8'h01, 8'h05, 8'h06};
        check_log("rst_mid", eo, ed);

        // owner drops valid for 5 cycles while req0 waits
        do_reset();
        use_src = 1'b1;
        src_cnt[1] = 4; src_base[1] = 8'h50;
        wait_log(1, 20, "pause_pre");
        src_cnt[0] = 2; src_base[0] = 8'h90;
        src_pause[1] = 1'b1;
        repeat (5) step(1'b1);
        cmp("pause_no_bytes", log_own.size(), 1);
        cmp("pause_gid", grant_id, 1);
        cmp("pause_busy", busy, 1);
        src_pause[1] = 1'b0;
        run_until_idle(60, "pause_done");
        eo = '{1, 1, 1, 1, 0, 0};
        ed = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h90, 8'h91};
        check_log("pause", eo, ed);

        // randomized traffic against the model
        do_reset();
        use_src = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) req_last[i] = ($urandom_range(0, 19) == 0);
            req_data = $urandom;
            tx_full  = ($urandom_range(0, 4) == 0);
            step(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
